// File: rtl/bin_window_streamer_if.sv
// Pixel-in / window-out handshake bundle for bin_window_streamer.
// master = the streamer itself, slave = the pixel source and window consumer.
interface bin_window_streamer_if #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int WIN    = 6,
  parameter int STRIDE = 2
);
  localparam int NOUT_X = (IMG_W - WIN) / STRIDE + 1;
  localparam int NOUT_Y = (IMG_H - WIN) / STRIDE + 1;
  localparam int XW     = (NOUT_X > 1) ? $clog2(NOUT_X) : 1;
  localparam int YW     = (NOUT_Y > 1) ? $clog2(NOUT_Y) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_bit;
  logic                 win_valid;
  logic                 win_ready;
  logic [WIN*WIN-1:0]   win;
  logic [YW-1:0]        win_row;
  logic [XW-1:0]        win_col;
  logic                 frame_done;

  modport master (
    input  in_valid, in_bit, win_ready,
    output in_ready, win_valid, win, win_row, win_col, frame_done
  );

  modport slave (
    output in_valid, in_bit, win_ready,
    input  in_ready, win_valid, win, win_row, win_col, frame_done
  );
endinterface

// File: rtl/bin_window_streamer.sv
// Purpose: buffers WIN image rows of a raster 1-bit stream and emits WINxWIN windows at STRIDE.
// Latency: first window valid the cycle after the last pixel of row WIN-1; then one window/cycle.
// Backpressure: pixels accepted only while filling; windows hold stable until win_ready.
module bin_window_streamer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int WIN    = 6,
  parameter int STRIDE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bin_window_streamer_if.master  bus
);
  localparam int NOUT_X = (IMG_W - WIN) / STRIDE + 1;
  localparam int NOUT_Y = (IMG_H - WIN) / STRIDE + 1;
  localparam int XW     = (NOUT_X > 1) ? $clog2(NOUT_X) : 1;
  localparam int YW     = (NOUT_Y > 1) ? $clog2(NOUT_Y) : 1;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  // Row counters must reach IMG_H and the post-frame emit target IMG_H-1+STRIDE.
  localparam int RCW    = $clog2(IMG_H + STRIDE + 1);
  localparam int WW     = WIN * WIN;

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    col;
  logic [RCW-1:0]   row;
  logic [RCW-1:0]   next_emit_row;
  logic [IMG_W-1:0] cur_row;
  logic [IMG_W-1:0] rows [WIN];
  logic [IMG_W-1:0] rows_shift [WIN];
  logic [IMG_W-1:0] completed_row;
  logic [XW-1:0]    win_col_q;
  logic [YW-1:0]    win_row_q;
  logic [WW-1:0]    win_q;
  logic [WW-1:0]    win_next;
  logic             win_valid_q;
  logic             pix_acc;
  logic             row_end;
  logic             emit_start;
  logic             win_acc;
  logic             last_col;
  int               left_amt;

  assign pix_acc    = bus.in_valid && (state == FILL);
  assign row_end    = pix_acc && (col == CW'(IMG_W - 1));
  assign emit_start = row_end && (row == next_emit_row);
  assign win_acc    = win_valid_q && bus.win_ready;
  assign last_col   = (win_col_q == XW'(NOUT_X - 1));

  always_comb begin
    completed_row      = cur_row;
    completed_row[col] = bus.in_bit;
    for (int k = 0; k < WIN - 1; k++) begin
      rows_shift[k] = rows[k + 1];
    end
    rows_shift[WIN-1] = completed_row;
  end

  // A new window row is cut from the buffer as it will look after this edge's shift.
  always_comb begin
    logic [IMG_W-1:0] src_row;
    logic [IMG_W-1:0] shifted;
    left_amt = emit_start ? 0 : (int'(win_col_q) + 1) * STRIDE;
    win_next = '0;
    for (int i = 0; i < WIN; i++) begin
      src_row = emit_start ? rows_shift[i] : rows[i];
      shifted = src_row >> left_amt;
      win_next[i*WIN +: WIN] = shifted[WIN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      col           <= '0;
      row           <= '0;
      next_emit_row <= RCW'(WIN - 1);
      win_row_q     <= '0;
      win_col_q     <= '0;
      win_valid_q   <= 1'b0;
      win_q         <= '0;
      cur_row       <= '0;
      for (int k = 0; k < WIN; k++) begin
        rows[k] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (pix_acc) begin
            cur_row[col] <= bus.in_bit;
            if (row_end) begin
              col <= '0;
              row <= row + RCW'(1);
              for (int k = 0; k < WIN; k++) begin
                rows[k] <= rows_shift[k];
              end
              if (emit_start) begin
                state         <= EMIT;
                win_col_q     <= '0;
                win_row_q     <= (row == RCW'(WIN - 1)) ? '0 : win_row_q + YW'(1);
                win_q         <= win_next;
                win_valid_q   <= 1'b1;
                next_emit_row <= next_emit_row + RCW'(STRIDE);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        EMIT: begin
          if (win_acc) begin
            if (!last_col) begin
              win_col_q <= win_col_q + XW'(1);
              win_q     <= win_next;
            end else begin
              win_valid_q <= 1'b0;
              state       <= (row == RCW'(IMG_H)) ? DONE : FILL;
            end
          end
        end
        DONE: begin
          row           <= '0;
          col           <= '0;
          next_emit_row <= RCW'(WIN - 1);
          win_row_q     <= '0;
          win_col_q     <= '0;
          state         <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready   = (state == FILL);
  assign bus.win_valid  = win_valid_q;
  assign bus.win        = win_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = (state == DONE);
endmodule

// File: tb/tb_bin_window_streamer.sv
// Bench for bin_window_streamer on an 8x8 image with 6x6 windows at stride 2.
module tb_bin_window_streamer;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int WIN    = 6;
  localparam int STRIDE = 2;
  localparam int NOUT_X = (IMG_W - WIN) / STRIDE + 1;
  localparam int NOUT_Y = (IMG_H - WIN) / STRIDE + 1;
  localparam int NWIN   = NOUT_X * NOUT_Y;
  localparam int WW     = WIN * WIN;

  typedef struct {
    int            r;
    int            c;
    logic [WW-1:0] w;
  } win_t;

  typedef struct {
    int            kind;     // 0 diagonal, 1 all ones
    int            gap_pct;
    int            stall;
    logic [WW-1:0] exp [NWIN];
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_window_streamer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STRIDE(STRIDE)) bus ();

  bin_window_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STRIDE(STRIDE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic img [IMG_H][IMG_W];
  win_t got [$];
  win_t exp_q [$];
  vec_t vecs [4];
  int   cyc = 0;
  int   first_vld_cyc, last_pix_cyc, last_acc_cyc, done_cyc, done_cnt;
  bit   abort    = 1'b0;
  bit   stop_rnd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.win_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.win_valid && bus.win_ready) begin
        got.push_back('{int'(bus.win_row), int'(bus.win_col), bus.win});
        last_acc_cyc = cyc + 1;
      end
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference: every STRIDE-aligned WINxWIN crop of the image, raster order.
  function automatic void build_model();
    win_t e;
    exp_q.delete();
    for (int wr = 0; wr < NOUT_Y; wr++) begin
      for (int wc = 0; wc < NOUT_X; wc++) begin
        e.r = wr;
        e.c = wc;
        e.w = '0;
        for (int i = 0; i < WIN; i++)
          for (int j = 0; j < WIN; j++)
            e.w[i*WIN+j] = img[wr*STRIDE+i][wc*STRIDE+j];
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic fill_img(input int kind);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (kind)
          0:       img[r][c] = (r == c);
          1:       img[r][c] = 1'b1;
          default: img[r][c] = 1'($urandom_range(1));
        endcase
  endtask

  task automatic send_frame(input int gap_pct);
    bit acc;
    int n;
    @(posedge clk); #1;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
        if (abort) begin
          bus.in_valid = 1'b0;
          return;
        end
        bus.in_valid = 1'b1;
        bus.in_bit   = img[r][c];
        acc = 1'b0;
        n   = 0;
        while (!acc && !abort && n < 300) begin
          @(negedge clk);
          acc = bus.in_ready;
          @(posedge clk); #1;
          n++;
        end
        if (abort) begin
          bus.in_valid = 1'b0;
          return;
        end
        if (!acc) begin
          note_timeout("pixel_accept");
          bus.in_valid = 1'b0;
          return;
        end
        if (r == WIN - 1 && c == IMG_W - 1) last_pix_cyc = cyc;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic stall_first(input int cycles, input logic [WW-1:0] w_exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.win_valid && n < 3000);
    if (!bus.win_valid) begin
      note_timeout("stall_wait_window");
    end else begin
      for (int k = 0; k < cycles; k++) begin
        @(negedge clk);
        chk("stall_win_valid", bus.win_valid, 1);
        chk("stall_win", bus.win, w_exp);
        chk("stall_win_row", bus.win_row, 0);
        chk("stall_win_col", bus.win_col, 0);
        chk("stall_in_ready", bus.in_ready, 0);
      end
    end
    @(posedge clk); #1;
    bus.win_ready = 1'b1;
  endtask

  task automatic rnd_ready();
    while (!stop_rnd) begin
      @(posedge clk); #1;
      bus.win_ready = ($urandom_range(99) < 60);
    end
    bus.win_ready = 1'b1;
  endtask

  task automatic run_frame(input int kind, input int gap_pct, input int stall, input bit rnd);
    int n;
    @(posedge clk); #1;
    fill_img(kind);
    build_model();
    got.delete();
    first_vld_cyc = -1;
    last_pix_cyc  = -2;
    done_cnt      = 0;
    done_cyc      = -1;
    stop_rnd      = 1'b0;
    bus.win_ready = (stall > 0) ? 1'b0 : 1'b1;
    fork
      send_frame(gap_pct);
      begin if (stall > 0) stall_first(stall, exp_q[0].w); end
      begin if (rnd) rnd_ready(); end
      begin
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        if (done_cnt == 0) note_timeout("frame_done_wait");
        repeat (3) @(negedge clk);
        stop_rnd = 1'b1;
      end
    join
    chk("window_count", got.size(), NWIN);
    for (int k = 0; k < NWIN && k < got.size(); k++) begin
      chk("model_win_row", got[k].r, exp_q[k].r);
      chk("model_win_col", got[k].c, exp_q[k].c);
      chk("model_win", got[k].w, exp_q[k].w);
    end
    chk("first_window_latency", first_vld_cyc, last_pix_cyc);
    chk("frame_done_pulses", done_cnt, 1);
    chk("frame_done_timing", done_cyc, last_acc_cyc);
  endtask

  task automatic set_vec(input int idx, input int kind, input int gap, input int stall,
                         input logic [WW-1:0] e0, input logic [WW-1:0] e1,
                         input logic [WW-1:0] e2, input logic [WW-1:0] e3);
    vecs[idx].kind    = kind;
    vecs[idx].gap_pct = gap;
    vecs[idx].stall   = stall;
    vecs[idx].exp[0]  = e0;
    vecs[idx].exp[1]  = e1;
    vecs[idx].exp[2]  = e2;
    vecs[idx].exp[3]  = e3;
  endtask

  task automatic check_vec(input int v);
    for (int k = 0; k < NWIN; k++) begin
      if (k < got.size()) begin
        chk("vec_win_row", got[k].r, k / NOUT_X);
        chk("vec_win_col", got[k].c, k % NOUT_X);
        chk("vec_win", got[k].w, vecs[v].exp[k]);
      end else begin
        note_timeout("vec_window_missing");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Diagonal image: (0,0) and (1,1) see i==j, (0,1) sees i==j+2, (1,0) sees i+2==j.
    set_vec(0, 0, 0,  0, 36'h8_1020_4081, 36'h2_0408_1000, 36'h0_0081_0204, 36'h8_1020_4081);
    set_vec(1, 0, 50, 0, 36'h8_1020_4081, 36'h2_0408_1000, 36'h0_0081_0204, 36'h8_1020_4081);
    set_vec(2, 0, 0, 10, 36'h8_1020_4081, 36'h2_0408_1000, 36'h0_0081_0204, 36'h8_1020_4081);
    set_vec(3, 1, 0,  0, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF);

    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    bus.win_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_win_valid", bus.win_valid, 0);
    chk("reset_frame_done", bus.frame_done, 0);
    chk("reset_win", bus.win, 0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].kind, vecs[v].gap_pct, vecs[v].stall, 1'b0);
      check_vec(v);
    end

    for (int f = 0; f < 3; f++) begin
      run_frame(2, int'($urandom_range(70)), 0, 1'b1);
    end

    // Reset one cycle after window (0,0) is taken, while (0,1) is still pending.
    @(posedge clk); #1;
    fill_img(0);
    got.delete();
    bus.win_ready = 1'b1;
    fork
      send_frame(0);
      begin
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (got.size() < 1 && n < 3000);
        if (got.size() < 1) note_timeout("mid_emit_wait");
        rst   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_emit_rst_win_valid", bus.win_valid, 0);
        chk("mid_emit_rst_win", bus.win, 0);
        chk("mid_emit_rst_frame_done", bus.frame_done, 0);
      end
    join
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    abort        = 1'b0;
    run_frame(0, 0, 0, 1'b0);
    check_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
